inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 195 +++++++++++++++++++
 tb/tb_inst_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage with a small fetch buffer.
//
// Issues word-addressed requests to instruction memory on behalf of decode,
// tracks outstanding requests in an in-order PC queue, and pairs each returned
// instruction word with its PC in a fetch buffer whose head is presented to
// decode. A flush empties the buffer and marks every outstanding request so
// its response is discarded when it returns.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   stall          decode stall; head is not consumed while high
//   dec2if_i       {pc[31:2], pcValid} next fetch address and fetch enable
//   flush_i        redirect; discard buffered and in-flight instructions
//   imem_req_o     instruction memory request
//   imem_addr_o    request word address (pc[31:2])
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid (responses return in request order)
//   imem_rdata_i   response instruction word
//   if2dec_o       {pc[31:2], inst32, instValid} buffer head to decode
//
// BUF_DEPTH must be a power of two and at least 2; it bounds the sum of
// buffered entries and outstanding requests.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;
  typedef struct packed {
    logic [31:2] pc;
    logic        pcValid;
  } dec2ifPkt;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] inst32;
    logic        instValid;
  } if2decPkt;
endpackage

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  dec2ifPkt    dec2if_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output if2decPkt    if2dec_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(BUF_DEPTH);

  // Request holding register: set when a request is raised but not granted
  // in the same cycle, so address and request stay stable until the grant.
  logic          req_pending_reg;
  logic [29:0]   req_addr_reg;

  // In-flight PC queue (oldest entry pairs with the next response).
  logic [29:0]   ifq_pc_reg [BUF_DEPTH];
  logic [PW-1:0] ifq_rd_reg;
  logic [PW-1:0] ifq_wr_reg;
  logic [CW-1:0] inflight_reg;
  // Number of oldest in-flight responses still to be thrown away after a flush.
  logic [CW-1:0] drop_reg;

  // Fetch buffer.
  logic [29:0]   buf_pc_reg   [BUF_DEPTH];
  logic [31:0]   buf_inst_reg [BUF_DEPTH];
  logic [PW-1:0] buf_rd_reg;
  logic [PW-1:0] buf_wr_reg;
  logic [CW-1:0] buf_count_reg;

  logic [CW:0]   occupancy;
  logic          req_start;
  logic          req_active;
  logic [29:0]   req_addr;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_drop;
  logic          buf_push;
  logic          buf_pop;
  logic          head_valid;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop_next;

  always_comb begin
    // Dropped-but-outstanding responses stay in inflight_reg, so they keep
    // occupying a slot until they actually return.
    occupancy  = {1'b0, buf_count_reg} + {1'b0, inflight_reg};
    req_start  = rst && !req_pending_reg && dec2if_i.pcValid && !flush_i &&
                 (occupancy < DEPTH_V);
    req_active = rst && (req_pending_reg || req_start);
    req_addr   = req_pending_reg ? req_addr_reg : dec2if_i.pc;
    req_fire   = req_active && imem_gnt_i;

    // A response with nothing outstanding is a stray and is ignored.
    rsp_fire   = rst && imem_rvalid_i && (inflight_reg != '0);
    rsp_drop   = rsp_fire && (flush_i || (drop_reg != '0));
    buf_push   = rsp_fire && !rsp_drop;

    head_valid = rst && (buf_count_reg != '0);
    buf_pop    = head_valid && !stall && !flush_i;

    inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_fire);

    // On flush every request still outstanding after this edge (including
    // one granted now) must be discarded; a response arriving in the flush
    // cycle is already excluded by inflight_next.
    if (flush_i) begin
      drop_next = inflight_next;
    end else if (rsp_fire && (drop_reg != '0)) begin
      drop_next = drop_reg - CW'(1);
    end else begin
      drop_next = drop_reg;
    end
  end

  assign imem_req_o  = req_active;
  assign imem_addr_o = rst ? req_addr : '0;

  // Head is read straight from the buffer registers so an entry written on
  // edge N is visible in cycle N+1 without any rdata-to-output path.
  always_comb begin
    if2dec_o = '0;
    if (head_valid) begin
      if2dec_o.pc        = buf_pc_reg[buf_rd_reg];
      if2dec_o.inst32    = buf_inst_reg[buf_rd_reg];
      if2dec_o.instValid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_pending_reg <= 1'b0;
      req_addr_reg    <= '0;
      ifq_rd_reg      <= '0;
      ifq_wr_reg      <= '0;
      inflight_reg    <= '0;
      drop_reg        <= '0;
      buf_rd_reg      <= '0;
      buf_wr_reg      <= '0;
      buf_count_reg   <= '0;
    end else begin
      if (req_start && !imem_gnt_i) begin
        req_pending_reg <= 1'b1;
        req_addr_reg    <= dec2if_i.pc;
      end else if (req_fire) begin
        req_pending_reg <= 1'b0;
      end

      if (req_fire) begin
        ifq_wr_reg <= ifq_wr_reg + PW'(1);
      end
      if (rsp_fire) begin
        ifq_rd_reg <= ifq_rd_reg + PW'(1);
      end
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;

      if (flush_i) begin
        buf_rd_reg    <= '0;
        buf_wr_reg    <= '0;
        buf_count_reg <= '0;
      end else begin
        if (buf_push) begin
          buf_wr_reg <= buf_wr_reg + PW'(1);
        end
        if (buf_pop) begin
          buf_rd_reg <= buf_rd_reg + PW'(1);
        end
        buf_count_reg <= buf_count_reg + CW'(buf_push) - CW'(buf_pop);
      end
    end
  end

  // Storage arrays carry no reset; validity comes from the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      ifq_pc_reg[ifq_wr_reg] <= req_addr;
    end
    if (buf_push) begin
      buf_pc_reg[buf_wr_reg]   <= ifq_pc_reg[ifq_rd_reg];
      buf_inst_reg[buf_wr_reg] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch.
//
// A driver process applies directed and randomized stimulus and plays the
// instruction memory. A monitor process keeps a transaction-level model
// (queue of buffered instructions, queue of outstanding requests with a
// dropped flag, pending-request state) and compares the DUT every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush_i = 1'b0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  dec2ifPkt    dec2if_i = '0;
  logic        imem_req_o;
  logic [29:0] imem_addr_o;
  if2decPkt    if2dec_o;

  inst_fetch #(.BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .dec2if_i      (dec2if_i),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if2dec_o      (if2dec_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [29:0] pc; logic [31:0] inst; } entry_t;
  typedef struct { logic [29:0] pc; bit dropped; } flight_t;

  entry_t      exp_q[$];   // instructions expected in the fetch buffer
  flight_t     fly_q[$];   // granted requests awaiting a response
  logic [29:0] mem_q[$];   // memory side: granted addresses to answer
  bit          pend_m = 1'b0;
  logic [29:0] pend_addr = '0;

  int n_vec = 0;
  int n_err = 0;
  int gnt_seen = 0;

  // Stimulus knobs (percent probabilities).
  int k_pv, k_stall, k_gnt, k_rv, k_flush, k_stray;
  bit k_pcinc, k_rrst, force_rst;
  logic [29:0] pc_cnt;

  function automatic logic [31:0] data_of(input logic [29:0] a);
    return 32'h13 ^ {a ^ 30'h40, 2'b00};
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Memory: remember every granted address so it can be answered in order.
  always @(negedge clk) begin
    if (rst && imem_req_o && imem_gnt_i) mem_q.push_back(imem_addr_o);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic        exp_req;
    logic [29:0] exp_addr;
    logic        exp_valid;
    flight_t     f;
    bit          rsp;
    if (!rst) begin
      check("reset_req_addr", 64'({imem_req_o, imem_addr_o}), 64'(0));
      check("reset_if2dec", 64'(if2dec_o), 64'(0));
      exp_q.delete();
      fly_q.delete();
      pend_m = 1'b0;
    end else begin
      exp_req  = pend_m || (dec2if_i.pcValid && !flush_i &&
                            (exp_q.size() + fly_q.size() < DEPTH));
      exp_addr = pend_m ? pend_addr : dec2if_i.pc;
      check("imem_req", 64'(imem_req_o), 64'(exp_req));
      if (exp_req) check("imem_addr", 64'(imem_addr_o), 64'(exp_addr));
      exp_valid = (exp_q.size() != 0);
      check("inst_valid", 64'(if2dec_o.instValid), 64'(exp_valid));
      if (exp_valid)
        check("head_pc_inst", 64'({if2dec_o.pc, if2dec_o.inst32}),
              64'({exp_q[0].pc, exp_q[0].inst}));
      if (imem_req_o && imem_gnt_i) gnt_seen++;

      // Advance the model by this cycle's events.
      rsp = imem_rvalid_i && (fly_q.size() != 0);
      if (rsp) f = fly_q.pop_front();
      if (exp_req && imem_gnt_i) begin
        fly_q.push_back('{exp_addr, 1'b0});
        pend_m = 1'b0;
      end else if (exp_req) begin
        pend_m    = 1'b1;
        pend_addr = exp_addr;
      end
      if (flush_i) begin
        exp_q.delete();
        foreach (fly_q[i]) fly_q[i].dropped = 1'b1;
      end else begin
        if (exp_valid && !stall) exp_q.delete(0);
        if (rsp && !f.dropped) exp_q.push_back('{f.pc, data_of(f.pc)});
      end
    end
  end

  // Apply n cycles of stimulus; returns 1 time unit after the last edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rst = !(force_rst || (k_rrst && ($urandom_range(0, 499) == 0)));
      if (!rst) mem_q.delete();
      dec2if_i.pcValid = pct(k_pv);
      dec2if_i.pc      = pc_cnt;
      if (k_pcinc) pc_cnt = pc_cnt + 30'd1;
      stall         = pct(k_stall);
      flush_i       = pct(k_flush);
      imem_gnt_i    = pct(k_gnt);
      imem_rdata_i  = $urandom;
      imem_rvalid_i = 1'b0;
      if (mem_q.size() != 0) begin
        if (pct(k_rv)) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = data_of(mem_q.pop_front());
        end
      end else if (pct(k_stray)) begin
        imem_rvalid_i = 1'b1;
      end
      $display("cyc rst=%0b pv=%0b pc=%08h stall=%0b flush=%0b gnt=%0b rv=%0b | req=%0b addr=%08h iv=%0b",
               rst, dec2if_i.pcValid, dec2if_i.pc, stall, flush_i, imem_gnt_i,
               imem_rvalid_i, imem_req_o, imem_addr_o, if2dec_o.instValid);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    k_pv = 100; k_stall = 0; k_gnt = 0; k_rv = 0; k_flush = 0; k_stray = 0;
    k_pcinc = 1'b0; k_rrst = 1'b0; force_rst = 1'b1; pc_cnt = 30'h7;
    cycles(3);
    force_rst = 1'b0;

    // Single fetch with immediate grant and next-cycle response.
    k_gnt = 100; k_rv = 100; pc_cnt = 30'h40; k_pv = 100;
    cycles(1);
    k_pv = 0;
    cycles(1);
    check("single_fetch", 64'(if2dec_o), 64'({30'h40, 32'h13, 1'b1}));
    cycles(2);

    // Backpressure: decode stalled, memory always ready.
    k_stall = 100; k_pv = 100; pc_cnt = 30'h100; k_pcinc = 1'b1; gnt_seen = 0;
    cycles(8);
    check("backpressure_reqs", 64'(gnt_seen), 64'(DEPTH));
    check("backpressure_full", 64'({imem_req_o, if2dec_o.instValid}), 64'(2'b01));
    k_stall = 0; k_pv = 0;
    cycles(DEPTH + 2);
    check("drained", 64'(if2dec_o.instValid), 64'(0));

    // Delayed grant while decode keeps changing the PC.
    k_gnt = 0; k_pv = 100; pc_cnt = 30'h20;
    cycles(3);
    check("held_addr", 64'({imem_req_o, imem_addr_o}), 64'({1'b1, 30'h20}));
    k_gnt = 100;
    cycles(1);
    k_pv = 0;
    cycles(4);

    // Flush with two requests in flight.
    pc_cnt = 30'h10; k_rv = 0; k_pv = 100;
    cycles(2);
    k_pv = 0; k_flush = 100;
    cycles(1);
    k_flush = 0; k_rv = 100;
    cycles(3);
    check("flush_dropped", 64'(if2dec_o.instValid), 64'(0));
    k_pcinc = 1'b0; pc_cnt = 30'h80; k_pv = 100;
    cycles(1);
    k_pv = 0;
    cycles(1);
    check("after_flush", 64'(if2dec_o), 64'({30'h80, data_of(30'h80), 1'b1}));
    cycles(2);

    // Continuous fetch across the address wrap.
    pc_cnt = 30'h3FFFFFFC; k_pcinc = 1'b1; k_pv = 100;
    cycles(16);
    k_pv = 0;
    cycles(4);

    // Reset during an ungranted request, then a stray response.
    pc_cnt = 30'h30; k_pcinc = 1'b0; k_gnt = 0; k_pv = 100;
    cycles(2);
    force_rst = 1'b1;
    cycles(1);
    force_rst = 1'b0; k_pv = 0;
    cycles(1);
    check("reset_abandon", 64'({imem_req_o, if2dec_o.instValid}), 64'(0));
    k_stray = 100;
    cycles(2);
    k_stray = 0;
    cycles(1);
    check("stray_ignored", 64'(if2dec_o.instValid), 64'(0));

    // Randomized traffic.
    k_pv = 70; k_stall = 30; k_gnt = 60; k_rv = 50; k_flush = 3; k_stray = 10;
    k_pcinc = 1'b1; k_rrst = 1'b1; pc_cnt = 30'h3FFFFF00;
    cycles(3000);
    k_rrst = 1'b0; k_flush = 0; k_pv = 0; k_stall = 0; k_gnt = 100; k_rv = 100; k_stray = 0;
    cycles(20);
    check("final_empty", 64'({imem_req_o, if2dec_o.instValid}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
